// File: rtl/ram_master_pkg.sv
// Shared state encoding and read-buffer sizing for the single-port RAM burst master.
package ram_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Two slots cover the one-cycle RAM read latency with full throughput.
  localparam int RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry read-data buffer between the RAM output register and the host read channel.
module ram_rd_fifo
  import ram_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [RD_FIFO_DEPTH];
  logic                  wptr;
  logic                  rptr;
  logic                  wr_en;
  logic                  rd_en;

  assign rd_en = pop & (count != 2'd0);
  assign wr_en = push & ((count != 2'(RD_FIFO_DEPTH)) | rd_en);
  assign dout  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) mem[i] <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (rd_en) rptr <= ~rptr;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sp_ram_master.sv
// Burst initiator owning a single-port RAM: streams write beats in, read beats out,
// and generates the wrapping address sequence.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// WRITE | one RAM write per wr handshake until the last beat
// READ  | issuing RAM reads into the output buffer, popping to the host
module sp_ram_master
  import ram_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic                  issue_all;
  logic                  inflight;
  logic                  done_q;
  logic [1:0]            fifo_count;
  logic                  wr_hs;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE);
  assign wr_hs     = wr_ready & wr_valid;
  assign ram_we    = wr_hs;
  assign ram_din   = wr_hs ? wr_data : '0;
  assign ram_addr  = addr_cnt;
  assign done      = done_q;
  assign rd_valid  = (fifo_count != 2'd0);
  assign pop       = rd_valid & rd_ready;

  // Slots already claimed once this cycle's pop retires; issue only if one stays free.
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == READ) & ~issue_all & (occ < 3'(RD_FIFO_DEPTH));

  ram_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (ram_dout),
    .pop   (pop),
    .dout  (rd_data),
    .count (fifo_count)
  );

  // The address counter does not step past the final beat, so ram_addr holds it when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      beat_cnt  <= '0;
      issue_cnt <= '0;
      issue_all <= 1'b0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_cnt  <= cmd_addr;
            beat_cnt  <= cmd_len;
            issue_cnt <= cmd_len;
            issue_all <= 1'b0;
            state     <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            if (beat_cnt == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - LEN_WIDTH'(1);
              addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        READ: begin
          if (issue) begin
            if (issue_cnt == '0) begin
              issue_all <= 1'b1;
            end else begin
              issue_cnt <= issue_cnt - LEN_WIDTH'(1);
              addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
            end
          end
          if (pop) begin
            if (beat_cnt == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_master.sv
// Directed bench for sp_ram_master with a behavioural single-port RAM attached.
module tb_sp_ram_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, done;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;

  logic [7:0] mem [0:15];
  logic       loaded = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sp_ram_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: registered read, one-cycle latency; preloaded with 0x10 + address.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
      loaded <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_wr_ready"},  wr_ready, 0);
    chk({tag, "_rd_valid"},  rd_valid, 0);
    chk({tag, "_rd_data"},   rd_data, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_ram_we"},    ram_we, 0);
    chk({tag, "_ram_addr"},  ram_addr, 0);
    chk({tag, "_ram_din"},   ram_din, 0);
  endtask

  logic [7:0] exp_rd [4];
  logic [6:0] gap_pat;
  logic [7:0] gap_data [3];
  int k;
  int b;

  initial begin
    rst_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 8'h5A; rd_ready = 0;
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Write burst addr 2, len 3, data A0..A3 with wr_valid held high.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd2; cmd_len = 4'd3;
    wr_valid = 1; wr_data = 8'hA0;
    #1 chk("wr1_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'hA0 + i);
      #1;
      chk("wr1_we", ram_we, 1);
      chk("wr1_addr", ram_addr, 2 + i);
      chk("wr1_din", ram_din, 8'hA0 + i);
      chk("wr1_done_low", done, 0);
      step();
    end
    wr_valid = 0;
    #1;
    chk("wr1_done", done, 1);
    chk("wr1_busy", busy, 0);
    chk("wr1_we_off", ram_we, 0);
    chk("wr1_addr_hold", ram_addr, 5);
    step();
    chk("wr1_done_pulse", done, 0);

    // Read back addr 2, len 3, rd_ready high.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd2; cmd_len = 4'd3; rd_ready = 1;
    step();
    cmd_valid = 0;
    #1;
    chk("rd1_c1_addr", ram_addr, 2);
    chk("rd1_c1_valid", rd_valid, 0);
    step();
    #1 chk("rd1_c2_valid", rd_valid, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rd1_valid", rd_valid, 1);
      chk("rd1_data", rd_data, 8'hA0 + i);
      chk("rd1_done_low", done, 0);
      step();
    end
    #1;
    chk("rd1_done", done, 1);
    chk("rd1_valid_end", rd_valid, 0);
    chk("rd1_busy", busy, 0);
    step();

    // Wrapping read addr 14, len 3 under backpressure.
    exp_rd[0] = 8'h1E; exp_rd[1] = 8'h1F; exp_rd[2] = 8'h10; exp_rd[3] = 8'h11;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd14; cmd_len = 4'd3; rd_ready = 0;
    step();
    cmd_valid = 0;
    repeat (6) step();
    #1;
    chk("rd2_stall_valid", rd_valid, 1);
    chk("rd2_stall_head", rd_data, 8'h1E);
    chk("rd2_stall_busy", busy, 1);
    step();
    k = 0;
    for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
      rd_ready = (cyc % 2 == 0);
      #1;
      if (rd_valid && rd_ready) begin
        chk("rd2_data", rd_data, exp_rd[k]);
        k++;
      end
      step();
    end
    rd_ready = 0;
    chk("rd2_beats", k, 4);
    chk("rd2_done", done, 1);
    step();
    chk("rd2_no_extra", rd_valid, 0);

    // Gapped write addr 8, len 2; a command pulsed mid-burst must be ignored.
    gap_pat = 7'b1001001;
    gap_data[0] = 8'h55; gap_data[1] = 8'h66; gap_data[2] = 8'h77;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd8; cmd_len = 4'd2;
    step();
    cmd_valid = 0;
    b = 0;
    for (int c = 0; c < 7; c++) begin
      wr_valid = gap_pat[c];
      wr_data  = gap_pat[c] ? gap_data[b] : 8'hEE;
      if (c == 2) begin
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd0; cmd_len = 4'd0;
      end else begin
        cmd_valid = 0;
      end
      #1;
      chk("gap_we", ram_we, gap_pat[c]);
      if (c == 2) chk("gap_cmd_ready_busy", cmd_ready, 0);
      if (gap_pat[c]) begin
        chk("gap_addr", ram_addr, 8 + b);
        chk("gap_din", ram_din, gap_data[b]);
        b++;
      end
      step();
    end
    cmd_valid = 0;
    wr_valid = 1; wr_data = 8'hEE;
    #1;
    chk("gap_done", done, 1);
    chk("gap_we_idle", ram_we, 0);
    chk("gap_wr_ready_idle", wr_ready, 0);
    step();
    wr_valid = 0;
    chk("gap_mem8", mem[8], 8'h55);
    chk("gap_mem9", mem[9], 8'h66);
    chk("gap_mem10", mem[10], 8'h77);
    chk("gap_mem11", mem[11], 8'h1B);
    chk("gap_busy_after", busy, 0);

    // Reset during beat 2 of a 4-beat write at addr 0.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd0; cmd_len = 4'd3;
    step();
    cmd_valid = 0;
    wr_valid = 1; wr_data = 8'hC0;
    #1 chk("rst_beat1_we", ram_we, 1);
    step();
    wr_data = 8'hC1;
    rst_n = 0;
    #1;
    chk_reset_vals("rst_mid");
    step();
    chk("rst_mem0", mem[0], 8'hC0);
    chk("rst_mem1", mem[1], 8'h11);
    rst_n = 1; wr_valid = 0;
    step();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd0; cmd_len = 4'd0; rd_ready = 1;
    step();
    cmd_valid = 0;
    step();
    step();
    #1;
    chk("rst_rd_valid", rd_valid, 1);
    chk("rst_rd_data", rd_data, 8'hC0);
    step();
    #1 chk("rst_rd_done", done, 1);
    step();

    // Back-to-back: 1-beat write at 12, then read held valid through the done cycle.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd12; cmd_len = 4'd0;
    step();
    cmd_write = 0;
    wr_valid = 1; wr_data = 8'h99;
    #1;
    chk("b2b_cmd_ready_busy", cmd_ready, 0);
    chk("b2b_we", ram_we, 1);
    step();
    wr_valid = 0;
    #1;
    chk("b2b_done", done, 1);
    chk("b2b_busy_gap", busy, 0);
    chk("b2b_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 0;
    #1;
    chk("b2b_busy_again", busy, 1);
    chk("b2b_rd_addr", ram_addr, 12);
    chk("b2b_done_pulse", done, 0);
    step();
    step();
    #1;
    chk("b2b_rd_valid", rd_valid, 1);
    chk("b2b_rd_data", rd_data, 8'h99);
    step();
    #1 chk("b2b_rd_done", done, 1);
    rd_ready = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_ram_master.md
# sp_ram_master

Burst initiator that owns the port of a synchronous single-port RAM (write-enable, address, write data, registered read data, one-cycle read latency). Accepts a burst command (direction, start address, length) from a host, streams write beats in or read beats out over valid/ready channels, and generates the RAM address sequence. Sits between a host or DMA-style client and the RAM instance, absorbing read latency and host backpressure.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 4, RAM address width; depth 2^ADDR_WIDTH
- LEN_WIDTH, 4, burst length field width; bursts of 1..2^LEN_WIDTH beats

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  beats minus one
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_WIDTH  write beat data
- rd_valid  out  1  read beat available
- rd_ready  in  1  host takes read beat
- rd_data  out  DATA_WIDTH  read beat data
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse, burst complete
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after its address is presented

## Operation
- States: IDLE, WRITE, READ. IDLE -> WRITE/READ on cmd handshake; latch cmd_addr into address counter, cmd_len into beat counter.
- cmd_ready = (state == IDLE); busy = (state != IDLE).
- WRITE: wr_ready = 1; on wr handshake ram_we = 1, ram_din = wr_data, ram_addr = counter (combinational from wr_valid/wr_data). Counter +1 per beat. Last beat -> IDLE.
- READ: issue one RAM read per cycle while (fifo_count + inflight − pop) < 2; pop = rd_valid & rd_ready. ram_dout captured into a 2-entry output FIFO the cycle after issue. rd_valid = FIFO non-empty; rd_data = FIFO head. READ -> IDLE when last beat popped.
- ram_we = 0 outside WRITE handshakes; ram_addr holds last value when idle.
- Address wraps modulo 2^ADDR_WIDTH (e.g. addr 15, len 2 on ADDR_WIDTH 4 -> 15, 0, 1).
- done: registered pulse in the first IDLE cycle after the final beat; cmd_ready is already high that cycle, so back-to-back bursts lose no further cycles.
- Commands offered while busy are ignored (cmd_ready low). wr_valid outside WRITE is ignored, never written.
- Reset (any time, including mid-burst): state IDLE, counters 0, FIFO empty, inflight cleared; burst aborted, no further RAM writes.

## Timing
- Reset values: cmd_ready 1, wr_ready 0, rd_valid 0, rd_data 0, busy 0, done 0, ram_we 0, ram_addr 0, ram_din 0.
- Write: cmd accepted edge 0; first beat can be written at edge 1; 1 beat/cycle with wr_valid held high; N-beat burst done high cycle N+1.
- Read: cmd edge 0; addr issued cycle 1; ram_dout valid cycle 2; rd_valid first high cycle 3. With rd_ready held high, 1 beat/cycle; N-beat burst done high cycle N+3.
- rd_ready low: at most 2 beats buffered + 0 inflight; issue resumes the cycle a pop occurs.

## Structure
- Shared package ram_master_pkg: state encoding constants (IDLE, WRITE, READ), read FIFO depth constant (2).
- One sub-module: ram_rd_fifo, 2-entry DATA_WIDTH FIFO with count output, async active-low reset.

## Test plan
- Write burst addr 2, len 3, data A0..A3, wr_valid always high -> ram_we high 4 consecutive cycles, ram_addr 2..5, done at cycle 5.
- Read back addr 2, len 3, rd_ready high -> rd_data A0..A3 on consecutive cycles from cycle 3, done at cycle 7.
- Read addr 14, len 3 with rd_ready toggling 1/0 -> addresses 14, 15, 0, 1; no beat lost or duplicated; never >2 beats buffered.
- Write with wr_valid gapped (1,0,0,1,...) -> ram_we only on handshake cycles; cmd_valid pulsed mid-burst -> ignored.
- Assert rst_n low during beat 2 of a 4-beat write -> ram_we 0 immediately, all outputs at reset values, subsequent 1-beat read from addr 0 succeeds.
- Back-to-back: new cmd held valid through done cycle -> accepted in the done cycle, busy low for exactly that one cycle.
